mem_fifo_ctrl: RTL and testbench

Synchronous FIFO controller wrapped around the team's dual-port `Mem` RAM. It turns the RAM into a valid/ready stream buffer: it accepts words from the upstream producer, drives the RAM write port, reads the RAM's combinational output, and presents a registered valid/ready stream to the downstream consumer. The RAM's `write_clock` and `read_clock` are both tied to this block's `clock`. `D_WIDTH`, `A_WIDTH` and `A_MAX` pass straight through to the `Mem` instance.

---
 rtl/mem_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_mem_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: valid/ready stream FIFO built around an external dual-port RAM
// with a combinational read port. The RAM holds up to A_MAX words and one
// more word sits in the registered output stage, so total capacity is A_MAX+1.
module mem_fifo_ctrl #(
    parameter int D_WIDTH = 64,
    parameter int A_WIDTH = 7,
    parameter int A_MAX   = 128
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] mem_data,
    output logic [A_WIDTH-1:0] mem_write_addr,
    output logic               mem_we,
    output logic [A_WIDTH-1:0] mem_read_addr,
    input  logic [D_WIDTH-1:0] mem_q,
    output logic [A_WIDTH:0]   level,
    output logic               full,
    output logic               empty
);

    localparam logic [A_WIDTH-1:0] PTR_LAST = A_WIDTH'(A_MAX - 1);
    localparam logic [A_WIDTH:0]   CNT_MAX  = (A_WIDTH + 1)'(A_MAX);

    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0]   ram_count_q, ram_count_d;
    logic               out_valid_q, out_valid_d;
    logic [D_WIDTH-1:0] out_data_q, out_data_d;
    logic               clr;
    logic               push;
    logic               load;

    // Depth need not be a power of two, so wrap explicitly at A_MAX-1.
    function automatic logic [A_WIDTH-1:0] ptr_inc(input logic [A_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode and status flags; reset/flush suppress any RAM access.
    always_comb begin
        clr            = reset | flush;
        full           = (ram_count_q == CNT_MAX);
        in_ready       = ~full;
        push           = in_valid & in_ready & ~clr;
        load           = (ram_count_q != '0) & (~out_valid_q | out_ready) & ~clr;
        mem_we         = push;
        mem_write_addr = wr_ptr_q;
        mem_data       = in_data;
        mem_read_addr  = rd_ptr_q;
        level          = ram_count_q + {{A_WIDTH{1'b0}}, out_valid_q};
        empty          = (level == '0);
        out_valid      = out_valid_q;
        out_data       = out_data_q;
    end

    // Next-state: pointers advance on their events, output stage refills from RAM
    // whenever it is empty or being consumed, and count tracks RAM occupancy only.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (load) begin
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            out_data_d  = mem_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
        case ({push, load})
            2'b10:   ram_count_d = ram_count_q + 1'b1;
            2'b01:   ram_count_d = ram_count_q - 1'b1;
            default: ram_count_d = ram_count_q;
        endcase
    end

    // State registers; flush clears exactly like reset. RAM contents are left alone.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: two FIFO instances (depth 128 and depth 100) each backed by
// a behavioural RAM and checked every cycle against a queue-based reference.
module tb_mem_fifo_ctrl;

    localparam int DW   = 64;
    localparam int AW   = 7;
    localparam int AMAX = 128;
    localparam int BMAX = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (default depth 128) ----------------
    logic          a_reset, a_flush, a_in_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data, a_mem_data, a_mem_q;
    logic          a_in_ready, a_out_valid, a_mem_we, a_full, a_empty;
    logic [AW-1:0] a_mem_waddr, a_mem_raddr;
    logic [AW:0]   a_level;

    mem_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AMAX)) dut_a (
        .clock(clk), .reset(a_reset), .flush(a_flush),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .mem_data(a_mem_data), .mem_write_addr(a_mem_waddr), .mem_we(a_mem_we),
        .mem_read_addr(a_mem_raddr), .mem_q(a_mem_q),
        .level(a_level), .full(a_full), .empty(a_empty)
    );

    // ---------------- instance B (depth 100, wrap test) ----------------
    logic          b_reset, b_flush, b_in_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data, b_mem_data, b_mem_q;
    logic          b_in_ready, b_out_valid, b_mem_we, b_full, b_empty;
    logic [AW-1:0] b_mem_waddr, b_mem_raddr;
    logic [AW:0]   b_level;

    mem_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(BMAX)) dut_b (
        .clock(clk), .reset(b_reset), .flush(b_flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .mem_data(b_mem_data), .mem_write_addr(b_mem_waddr), .mem_we(b_mem_we),
        .mem_read_addr(b_mem_raddr), .mem_q(b_mem_q),
        .level(b_level), .full(b_full), .empty(b_empty)
    );

    // Behavioural RAMs: synchronous write, combinational read
    logic [DW-1:0] ram_a [128];
    logic [DW-1:0] ram_b [128];
    always @(posedge clk) if (a_mem_we) ram_a[a_mem_waddr] <= a_mem_data;
    always @(posedge clk) if (b_mem_we) ram_b[b_mem_waddr] <= b_mem_data;
    assign a_mem_q = ram_a[a_mem_raddr];
    assign b_mem_q = ram_b[b_mem_raddr];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference models ----------------
    // Each model: a queue of words held in RAM, plus the output-stage word.
    // Addresses are counts of writes/reads taken modulo the depth.
    logic [DW-1:0] mq_a[$];
    logic [DW-1:0] mq_b[$];
    logic          mov_a = 1'b0, mov_b = 1'b0;
    logic [DW-1:0] mod_a = '0,   mod_b = '0;
    int            wc_a = 0, rc_a = 0, wc_b = 0, rc_b = 0;
    int            push_b = 0, cons_b = 0;
    bit            ld_a, ps_a, ld_b, ps_b;
    bit            chk_a = 0, chk_b = 0;
    bit            a_done = 0, b_done = 0;
    int            lvl_a, lvl_b;
    int            wraps_rd_b = 0, wraps_wr_b = 0;
    logic [AW-1:0] prev_raddr_b = '0;

    always @(posedge clk) begin
        if (a_reset || a_flush) begin
            mq_a.delete(); mov_a = 1'b0; mod_a = '0; wc_a = 0; rc_a = 0;
        end else begin
            ld_a = (mq_a.size() > 0) && (!mov_a || a_out_ready);
            ps_a = a_in_valid && (mq_a.size() < AMAX);
            if (ld_a) begin
                mod_a = mq_a.pop_front(); mov_a = 1'b1; rc_a = (rc_a + 1) % AMAX;
            end else if (mov_a && a_out_ready) begin
                mov_a = 1'b0;
            end
            if (ps_a) begin
                mq_a.push_back(a_in_data); wc_a = (wc_a + 1) % AMAX;
            end
        end
    end

    always @(posedge clk) begin
        if (b_reset || b_flush) begin
            mq_b.delete(); mov_b = 1'b0; mod_b = '0; wc_b = 0; rc_b = 0;
        end else begin
            ld_b = (mq_b.size() > 0) && (!mov_b || b_out_ready);
            ps_b = b_in_valid && (mq_b.size() < BMAX);
            if (mov_b && b_out_ready) cons_b++;
            if (ld_b) begin
                mod_b = mq_b.pop_front(); mov_b = 1'b1; rc_b = (rc_b + 1) % BMAX;
            end else if (mov_b && b_out_ready) begin
                mov_b = 1'b0;
            end
            if (ps_b) begin
                mq_b.push_back(b_in_data); wc_b = (wc_b + 1) % BMAX; push_b++;
            end
        end
    end

    // ---------------- per-cycle comparisons (opposite edge) ----------------
    always @(negedge clk) begin
        if (chk_a) begin
            lvl_a = mq_a.size() + int'(mov_a);
            check("a_in_ready",  64'(a_in_ready),  64'(mq_a.size() != AMAX));
            check("a_full",      64'(a_full),      64'(mq_a.size() == AMAX));
            check("a_empty",     64'(a_empty),     64'(lvl_a == 0));
            check("a_level",     64'(a_level),     64'(lvl_a));
            check("a_out_valid", 64'(a_out_valid), 64'(mov_a));
            check("a_out_data",  a_out_data,       mod_a);
            check("a_mem_we",    64'(a_mem_we),
                  64'(a_in_valid && mq_a.size() != AMAX && !a_reset && !a_flush));
            check("a_rd_addr",   64'(a_mem_raddr), 64'(rc_a));
            if (a_mem_we) begin
                check("a_wr_addr",  64'(a_mem_waddr), 64'(wc_a));
                check("a_mem_data", a_mem_data,       a_in_data);
            end
        end
        if (chk_b) begin
            lvl_b = mq_b.size() + int'(mov_b);
            check("b_in_ready",  64'(b_in_ready),  64'(mq_b.size() != BMAX));
            check("b_full",      64'(b_full),      64'(mq_b.size() == BMAX));
            check("b_empty",     64'(b_empty),     64'(lvl_b == 0));
            check("b_level",     64'(b_level),     64'(lvl_b));
            check("b_out_valid", 64'(b_out_valid), 64'(mov_b));
            check("b_out_data",  b_out_data,       mod_b);
            check("b_rd_addr",   64'(b_mem_raddr), 64'(rc_b));
            if (b_mem_we) begin
                check("b_wr_addr",  64'(b_mem_waddr), 64'(wc_b));
                check("b_mem_data", b_mem_data,       b_in_data);
                if (b_mem_waddr == AW'(BMAX - 1)) wraps_wr_b++;
            end
            if (prev_raddr_b == AW'(BMAX - 1) && b_mem_raddr == '0) wraps_rd_b++;
            prev_raddr_b = b_mem_raddr;
        end
    end

    // ---------------- instance A stimulus ----------------
    initial begin
        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        @(posedge clk); #1;
        chk_a = 1;
        step();
        a_reset = 1'b0;

        // single word, held until consumer ready
        a_in_valid = 1'b1; a_in_data = 64'hDEAD_BEEF_0000_0001;
        step();
        a_in_valid = 1'b0;
        step();
        check("single_lat1", 64'(a_out_valid), 64'd1);
        repeat (3) step();
        check("single_hold", a_out_data, 64'hDEAD_BEEF_0000_0001);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("single_empty", 64'(a_empty), 64'd1);

        // fill to A_MAX+1, one refused push, then drain
        for (int i = 0; i <= AMAX; i++) begin
            a_in_valid = 1'b1; a_in_data = 64'(i);
            step();
        end
        check("fill_level", 64'(a_level), 64'(AMAX + 1));
        a_in_data = 64'd999;
        step();
        a_in_valid = 1'b0;
        check("fill_refuse", 64'(a_level), 64'(AMAX + 1));
        a_out_ready = 1'b1;
        repeat (AMAX + 6) step();
        a_out_ready = 1'b0;

        // streaming
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a_in_data = 64'(1000 + i);
            step();
        end
        a_in_valid = 1'b0;
        repeat (5) step();
        a_out_ready = 1'b0;

        // flush mid-burst
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1; a_in_data = 64'(5000 + i);
            step();
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (3) step();
        a_out_ready = 1'b0;
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 64'd77;
        step();
        a_flush = 1'b0; a_in_data = 64'h55;
        check("flush_level", 64'(a_level), 64'd0);
        step();
        a_in_valid = 1'b0;
        repeat (3) step();
        check("flush_next", a_out_data, 64'h55);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;

        // randomized traffic with occasional flush/reset
        for (int i = 0; i < 3000; i++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            a_in_data   = {$urandom, $urandom};
            a_flush     = ($urandom_range(0, 249) == 0);
            a_reset     = ($urandom_range(0, 499) == 0);
            step();
        end
        a_flush = 1'b0; a_reset = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_done = 1;
    end

    // ---------------- instance B stimulus: pointer wrap ----------------
    initial begin
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        @(posedge clk); #1;
        chk_b = 1;
        step();
        b_reset = 1'b0;
        for (int c = 0; c < 6000 && cons_b < 250; c++) begin
            b_in_valid  = (push_b < 250) && ($urandom_range(0, 2) != 0);
            b_out_ready = (c % 400 < 150) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
            b_in_data   = {$urandom, $urandom};
            step();
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        check("b_drained",  64'(cons_b), 64'd250);
        check("b_rd_wrap",  64'(wraps_rd_b > 0), 64'd1);
        check("b_wr_wrap",  64'(wraps_wr_b > 0), 64'd1);
        b_done = 1;
    end

    // ---------------- completion ----------------
    initial begin
        for (int c = 0; c < 20000 && !(a_done && b_done); c++) @(posedge clk);
        check("finish_in_time", 64'(a_done && b_done), 64'd1);
        @(posedge clk);
        chk_a = 0; chk_b = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
